// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Register byte offsets inside the 8-byte window
    localparam logic [2:0] UART_TXDATA_OFS = 3'd0;
    localparam logic [2:0] UART_STATUS_OFS = 3'd4;

    // STATUS register bit positions
    localparam int STAT_BUSY_BIT = 0;
    localparam int STAT_FULL_BIT = 1;
    localparam int STAT_OVRN_BIT = 2;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; dout always shows the head entry.
// Latency: a push is visible on dout/empty/count one cycle after its edge.
// Backpressure: push is ignored when full unless a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so push-while-full is legal then
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because empty gates every read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// MMIO UART transmitter: TXDATA stores queue bytes, serialized as 8N1 on TxD.
// Latency: store at edge k pops at edge k+1 when idle; TxD start bit follows.
// Backpressure: stores to a full FIFO are dropped and set sticky overrun.
module mmio_uart_tx
    import uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Sel,
    output logic        TxD,
    output logic        TxBusy
);

    localparam int          CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    // Address decode
    logic [31:0] adr_word;
    logic [31:0] ofs;
    logic        in_win;
    logic        hit_status;
    logic        wr_txdata;
    logic        wr_status;

    // FIFO interface
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic [CNT_W-1:0] fifo_count;
    logic             fsm_pop;

    // Status
    logic overrun;
    logic ovr_set;

    // TX engine
    tx_state_t  state_q, state_d;
    logic [2:0]  bit_q, bit_d;
    logic [15:0] baud_q, baud_d;
    logic [7:0]  shift_q, shift_d;
    logic        txd_q, txd_d;
    logic        baud_end;

    logic unused_bits;
    assign unused_bits = ^{WriteData[31:8], ofs[1:0], fifo_count};

    // Byte lanes are ignored; window covers BASE..BASE+7
    assign adr_word   = {DataAdr[31:2], 2'b00};
    assign ofs        = adr_word - BASE_ADDR;
    assign in_win     = (ofs[31:3] == '0);
    assign hit_status = in_win && ({ofs[2], 2'b00} == UART_STATUS_OFS);
    assign wr_txdata  = MemWrite && in_win && ({ofs[2], 2'b00} == UART_TXDATA_OFS);
    assign wr_status  = MemWrite && hit_status;
    assign Sel        = in_win;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata),
        .pop   (fsm_pop),
        .din   (WriteData[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A store is only lost when full and the engine is not draining this cycle
    assign ovr_set = wr_txdata & fifo_full & ~fsm_pop;
    assign TxBusy  = ~fifo_empty | (state_q != IDLE);
    assign TxD     = txd_q;

    // Sticky overrun: a same-cycle set beats a STATUS-write clear
    always_ff @(posedge clk) begin
        if (reset)          overrun <= 1'b0;
        else if (ovr_set)   overrun <= 1'b1;
        else if (wr_status) overrun <= 1'b0;
    end

    // Register read mux; only STATUS returns data
    always_comb begin
        ReadData = '0;
        if (hit_status) begin
            ReadData[STAT_BUSY_BIT] = TxBusy;
            ReadData[STAT_FULL_BIT] = fifo_full;
            ReadData[STAT_OVRN_BIT] = overrun;
        end
    end

    // TX engine state; TxD comes straight from a flop so the line never glitches
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bit_q   <= '0;
            baud_q  <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign baud_end = (baud_q == BAUD_LAST);

    // Next-state logic; txd_d is the line level for the cycle after this edge
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        baud_d  = baud_q;
        shift_d = shift_q;
        txd_d   = txd_q;
        fsm_pop = 1'b0;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (!fifo_empty) begin
                    fsm_pop = 1'b1;
                    shift_d = fifo_dout;
                    state_d = START;
                    baud_d  = '0;
                    bit_d   = '0;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    txd_d   = shift_q[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                        txd_d   = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    state_d = IDLE;
                    baud_d  = '0;
                    txd_d   = 1'b1;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx with a queue-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] A_TX  = BASE;
    localparam logic [31:0] A_ST  = BASE + 32'd4;
    localparam int          HN    = 8192;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Sel;
    logic        TxD;
    logic        TxBusy;

    mmio_uart_tx #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Sel       (Sel),
        .TxD       (TxD),
        .TxBusy    (TxBusy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference model: byte queue, frame clock and sticky overrun
    logic [7:0] mq[$];
    int         ft    = -1;   // cycle index inside the current frame, -1 when idle
    logic [7:0] cur   = 8'h00;
    logic       m_ovr = 1'b0;

    function automatic logic m_busy();
        return (mq.size() > 0) || (ft >= 0);
    endfunction

    function automatic logic exp_txd();
        int b;
        if (ft < 0) return 1'b1;
        b = ft / CPB;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return cur[b-1];
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] adr);
        logic [31:0] w;
        w = {adr[31:2], 2'b00};
        if (w == A_ST) return {29'b0, m_ovr, (mq.size() == DEPTH), m_busy()};
        return 32'h0;
    endfunction

    function automatic logic exp_sel(input logic [31:0] adr);
        logic [31:0] w;
        w = {adr[31:2], 2'b00};
        return (w == A_TX) || (w == A_ST);
    endfunction

    logic        hist_txd  [HN];
    logic        hist_busy [HN];
    int          ncyc = 0;
    logic [31:0] last_rd;
    logic        last_sel;

    // One bus cycle: drive, check comb outputs, clock, update model, check line
    task automatic cyc(input logic rst, input logic mw, input logic [31:0] adr, input logic [31:0] wd);
        logic [31:0] w;
        logic        full_pre, pop_now, wr_tx, wr_st;
        reset     = rst;
        MemWrite  = mw;
        DataAdr   = adr;
        WriteData = wd;
        #1;
        last_rd  = ReadData;
        last_sel = Sel;
        check("rdata", ReadData, exp_rd(adr));
        check("sel", 32'(Sel), 32'(exp_sel(adr)));
        @(posedge clk);
        w     = {adr[31:2], 2'b00};
        wr_tx = mw && (w == A_TX);
        wr_st = mw && (w == A_ST);
        if (rst) begin
            mq.delete();
            ft    = -1;
            m_ovr = 1'b0;
        end else begin
            full_pre = (mq.size() == DEPTH);
            pop_now  = (ft < 0) && (mq.size() > 0);
            if (pop_now) begin
                cur = mq.pop_front();
                ft  = 0;
            end else if (ft >= 0) begin
                ft++;
                if (ft == 10 * CPB) ft = -1;
            end
            if (wr_tx && (!full_pre || pop_now)) mq.push_back(wd[7:0]);
            if (wr_st) m_ovr = 1'b0;
            if (wr_tx && full_pre && !pop_now) m_ovr = 1'b1;
        end
        #1;
        check("txd", 32'(TxD), 32'(exp_txd()));
        check("busy", 32'(TxBusy), 32'(m_busy()));
        if (ncyc < HN) begin
            hist_txd[ncyc]  = TxD;
            hist_busy[ncyc] = TxBusy;
        end
        ncyc++;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, A_ST, 32'h0);
    endtask

    task automatic wr(input logic [31:0] adr, input logic [31:0] d);
        cyc(1'b0, 1'b1, adr, d);
    endtask

    // Independent line receiver: samples mid-bit, keeps frames with a valid stop bit
    logic [7:0] rx_q[$];
    int         rx_cnt = -1;
    logic [7:0] rx_sh  = 8'h00;

    always @(negedge clk) begin
        if (rx_cnt < 0) begin
            if (TxD === 1'b0) rx_cnt <= 1;
        end else begin
            rx_cnt <= rx_cnt + 1;
            if (rx_cnt >= CPB + CPB / 2 && rx_cnt < 9 * CPB && (rx_cnt % CPB) == CPB / 2)
                rx_sh <= {TxD, rx_sh[7:1]};
            else if (rx_cnt == 9 * CPB + CPB / 2) begin
                if (TxD === 1'b1) rx_q.push_back(rx_sh);
                rx_cnt <= -1;
            end
        end
    end

    initial begin
        int w0;
        int zeros;
        int r;
        logic [31:0] a;
        reset     = 1'b1;
        MemWrite  = 1'b0;
        DataAdr   = A_ST;
        WriteData = 32'h0;

        // Reset and quiet line
        cyc(1'b1, 1'b0, A_ST, 32'h0);
        check("t1_rst_txd", 32'(TxD), 32'd1);
        check("t1_rst_busy", 32'(TxBusy), 32'd0);
        idle(50);
        check("t1_status", last_rd, 32'h0);
        check("t1_idle_txd", 32'(TxD), 32'd1);

        // Single byte 0x55: alternating line, busy clears 41 cycles after the write
        w0 = ncyc;
        wr(A_TX, 32'hFFFF_FF55);
        idle(45);
        check("t2_before_fall", 32'(hist_txd[w0]), 32'd1);
        check("t2_fall", 32'(hist_txd[w0 + 1]), 32'd0);
        for (int i = 0; i < 10; i++)
            check($sformatf("t2_bit%0d", i), 32'(hist_txd[w0 + 2 + CPB * i]), 32'(i % 2));
        check("t2_busy40", 32'(hist_busy[w0 + 40]), 32'd1);
        check("t2_busy41", 32'(hist_busy[w0 + 41]), 32'd0);
        check("t2_rx_n", 32'(rx_q.size()), 32'd1);
        if (rx_q.size() > 0) check("t2_rx_byte", 32'(rx_q[0]), 32'h55);
        rx_q.delete();

        // Six back-to-back stores: sixth overflows
        for (int i = 0; i < 6; i++) wr(A_TX, 32'(i + 1));
        cyc(1'b0, 1'b0, A_ST, 32'h0);
        check("t3_status7", last_rd, 32'h7);
        idle(5 * 41 + 10);
        check("t3_rx_n", 32'(rx_q.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            if (i < rx_q.size()) check($sformatf("t3_rx%0d", i), 32'(rx_q[i]), 32'(i + 1));
        wr(A_ST, 32'h0);
        cyc(1'b0, 1'b0, A_ST, 32'h0);
        check("t3_ovr_clr", last_rd, 32'h0);
        rx_q.delete();

        // Store while full on the exact pop cycle
        w0 = ncyc;
        for (int i = 0; i < 5; i++) wr(A_TX, 32'h11 + 32'(i));
        idle(37);
        wr(A_TX, 32'hA5);
        cyc(1'b0, 1'b0, A_ST, 32'h0);
        check("t4_status", last_rd, 32'h3);
        idle(6 * 41 + 10);
        check("t4_rx_n", 32'(rx_q.size()), 32'd6);
        for (int i = 0; i < 5; i++)
            if (i < rx_q.size()) check($sformatf("t4_rx%0d", i), 32'(rx_q[i]), 32'h11 + 32'(i));
        if (rx_q.size() > 5) check("t4_rx_last", 32'(rx_q[5]), 32'hA5);
        rx_q.delete();

        // Reset mid-DATA aborts the frame and flushes the queue
        wr(A_TX, 32'h3C);
        wr(A_TX, 32'hC3);
        wr(A_TX, 32'h99);
        idle(15);
        cyc(1'b1, 1'b0, A_ST, 32'h0);
        check("t5_txd", 32'(TxD), 32'd1);
        check("t5_busy", 32'(TxBusy), 32'd0);
        cyc(1'b0, 1'b0, A_ST, 32'h0);
        check("t5_status", last_rd, 32'h0);
        idle(60);
        rx_q.delete();
        w0 = ncyc;
        idle(60);
        zeros = 0;
        for (int i = w0; i < ncyc; i++) if (hist_txd[i] == 1'b0) zeros++;
        check("t5_no_start", 32'(zeros), 32'd0);
        check("t5_rx_n", 32'(rx_q.size()), 32'd0);

        // Outside the window
        cyc(1'b0, 1'b0, BASE + 32'd8, 32'h0);
        check("t6_sel_p8", 32'(last_sel), 32'd0);
        check("t6_rd_p8", last_rd, 32'h0);
        cyc(1'b0, 1'b0, BASE - 32'd4, 32'h0);
        check("t6_sel_m4", 32'(last_sel), 32'd0);
        check("t6_rd_m4", last_rd, 32'h0);
        wr(32'd20, 32'd2);
        cyc(1'b0, 1'b0, A_ST + 32'd3, 32'h0);
        check("t6_sel_st3", 32'(last_sel), 32'd1);
        check("t6_status", last_rd, 32'h0);

        // Randomized traffic against the model
        repeat (3000) begin
            r = $urandom_range(0, 199);
            case ($urandom_range(0, 4))
                0: a = BASE;
                1: a = BASE + 32'd4;
                2: a = BASE + 32'd8;
                3: a = BASE - 32'd4;
                default: a = $urandom;
            endcase
            a = a | 32'($urandom_range(0, 3));
            if (r < 12)       wr(A_TX | 32'($urandom_range(0, 3)), $urandom);
            else if (r < 16)  wr(A_ST, $urandom);
            else if (r < 17)  cyc(1'b1, 1'b0, A_ST, 32'h0);
            else if (r < 30)  cyc(1'b0, 1'($urandom_range(0, 1)), a, $urandom);
            else if (r < 40)  begin
                repeat ($urandom_range(2, 6)) wr(A_TX, $urandom);
            end else          idle(1);
        end
        idle(DEPTH * 41 + 45);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter on the single-cycle ARM core's data bus, alongside data memory, downstream of `cpu_main`. Stores the core issue to its address window are queued in a small FIFO. The queued bytes are serialized as 8N1 frames on `TxD`. A status register lets firmware poll for space and completion, giving test programs a console output path besides the pass/fail store.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_1000: word-aligned base of the 2-register window.
- `CLKS_PER_BIT`, 16: `clk` cycles per UART bit; legal range 2..65535.
- `FIFO_DEPTH`, 4: TX FIFO entries; power of two, at least 2.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `MemWrite` input 1: core store strobe, same cycle as `DataAdr`/`WriteData`.
- `DataAdr` input 32: core data address.
- `WriteData` input 32: core store data.
- `ReadData` output 32: register read data, combinational from `DataAdr`.
- `Sel` output 1: `DataAdr` hits the window; the top level uses it to mux `ReadData` over dmem.
- `TxD` output 1: serial line, idle high.
- `TxBusy` output 1: FIFO non-empty or frame in progress.

## Operation
- Register map:
  - `BASE+0` TXDATA, write-only. A write pushes `WriteData[7:0]`; bits 31:8 are ignored. Reads return 0.
  - `BASE+4` STATUS. Reads return {29'b0, overrun, full, `TxBusy`}. Any write clears overrun.
  - `DataAdr[1:0]` is ignored.
  - Other addresses: `Sel`=0 and `ReadData`=0.
- Push rule: a TXDATA write is accepted if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise the byte is dropped and overrun sets. Overrun is sticky until a STATUS write or reset.
- STATUS write and overrun-set in the same cycle: set wins.
- TX FSM states: IDLE, START, DATA, STOP. A bit counter (0..7) and a baud counter (0..`CLKS_PER_BIT`-1) support it.
  - IDLE: `TxD`=1. If the FIFO is non-empty, pop into the shift register and go to START.
  - START: `TxD`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `TxD`=shift[0], LSB first, for `CLKS_PER_BIT` cycles per bit, 8 bits. Then go to STOP.
  - STOP: `TxD`=1 for `CLKS_PER_BIT` cycles, then go to IDLE.
- `TxD` is driven from a register so it is glitch-free.
- Baud counter: resets to 0 on each state or bit entry. It advances the bit at the cycle where count==`CLKS_PER_BIT`-1.
- Full flag: count==`FIFO_DEPTH`. The count width is $clog2(`FIFO_DEPTH`)+1. Pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Reset values, effective after the reset edge:
  - FSM in IDLE, FIFO empty, overrun 0.
  - `TxD`=1, `TxBusy`=0, shift register 0.
  - `ReadData`/`Sel` are combinational.
- A reset asserted mid-frame aborts it: `TxD` is 1 in the cycle after the reset edge, and queued bytes are discarded.
- Push latency: a write sampled at edge k is visible in STATUS.full/busy after edge k.
  - With the FSM in IDLE, the pop happens at edge k+1, and `TxD` falls to 0 after edge k+1.
- Frame length: START lasts `CLKS_PER_BIT` cycles, DATA 8×`CLKS_PER_BIT`, STOP `CLKS_PER_BIT`, followed by one IDLE cycle before the next START.
  - Back-to-back frame period is 10×`CLKS_PER_BIT`+1 cycles.
- `TxBusy` deasserts in the IDLE cycle after STOP completes, provided the FIFO is empty.
- Simultaneous push and pop while full: both succeed, the count is unchanged, and there is no overrun.

## Structure
- `uart_pkg` contains:
  - the `tx_state_t` enum (IDLE, START, DATA, STOP);
  - the register offset constants `UART_TXDATA_OFS`=0 and `UART_STATUS_OFS`=4;
  - the STATUS bit index constants.
- Sub-module `sync_fifo`:
  - parameterized width and depth;
  - ports `clk`, `reset`, push, pop, din, dout, full, empty, count;
  - dout shows the head entry (first-word fall-through).
- The top module holds address decode, the status/overrun logic, and the TX FSM.

## Test plan
The bench uses `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
1. Reset, then idle for 50 cycles -> `TxD`=1, `TxBusy`=0, STATUS read = 32'h0.
2. Store 32'hFFFF_FF55 to `BASE+0` -> `TxD` falls 1 cycle after the write edge. Over 10 bit-times of 4 cycles the sequence is 0,1,0,1,0,1,0,1,0,1. Busy clears at cycle 41 after the write.
3. Store 6 bytes 0x01..0x06 on consecutive cycles -> full=1 after the 5th write; the 6th write sets overrun=1, so STATUS = 32'h7. Bytes 0x01..0x05 go out in order, 41 cycles apart, and 0x06 is never sent. A subsequent STATUS write clears bit 2.
4. With the FIFO full and the FSM popping on a cycle, store 0xA5 on that same cycle -> accepted, no overrun, and 0xA5 is transmitted last.
5. Assert `reset` for one cycle in the middle of the DATA state -> `TxD`=1 the next cycle, STATUS = 0, no further start bits.
6. Read `BASE+8` and `BASE-4` -> `Sel`=0 and `ReadData`=0. A store of 2 to address 20 leaves the UART state unchanged.
